ula_multiciclo: RTL and testbench
=================================

Name: ula_multiciclo

Overview:
- Parametrised multi-cycle successor of the board ALU/PC datapath.
- Fetches 16-bit instructions from an external synchronous instruction ROM and executes them on an internal 16-entry register file with a parametrised data width.
- Adds R0 hardwired to zero, status flags, conditional/unconditional branches, HALT, free-run vs single-step control, and a debug register-read port for the HEX display logic.
- Sits between the instruction ROM and the board display/key glue.

Parameters:
- DATA_W, 16, register/ALU data width (must be >= 12).
- ADDR_W, 12, PC and instruction address width (1..12). Jump targets are truncated to ADDR_W.

Ports:
- clk  input  1  system clock (divided board clock); all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- run  input  1  1 = execute continuously; 0 = stop after the current instruction.
- step  input  1  one-cycle pulse; starts exactly one instruction when idle.
- imem_addr  output  ADDR_W  instruction ROM address.
- imem_data  input  16  ROM read data, valid one clk after imem_addr.
- pc  output  ADDR_W  address of the current/next instruction.
- retire  output  1  one-cycle pulse in WB of every executed instruction, including HALT.
- wb_en  output  1  register write strobe (WB cycle, rd != 0, ALU op).
- wb_addr  output  4  destination register.
- wb_data  output  DATA_W  value written.
- flag_z  output  1  last ALU result == 0.
- flag_c  output  1  carry (ADD/ADDI) or borrow (SUB/SUBI); 0 for logic ops.
- halted  output  1  HALT executed.
- busy  output  1  state not in {IDLE, HALT}.
- dbg_sel  input  4  debug register index.
- dbg_data  output  DATA_W  combinational read of R[dbg_sel]; R0 reads 0.

Behaviour:
- Instruction fields: op=[15:12], rd=[11:8], rs1=[7:4], rs2/imm4=[3:0], imm12=[11:0], imm8=[7:0]. Immediates are zero-extended.
- Opcodes:
  - 0 ADD rd=rs1+rs2; 1 SUB rd=rs1-rs2; 2 SLT rd=(rs1<rs2, unsigned)?1:0.
  - 3 AND, 4 OR, 5 XOR (register forms).
  - 6 ANDI, 7 ORI, 8 XORI, 9 ADDI, A SUBI (rd = rs1 op imm4).
  - B JMP pc=imm12; C BZ: if R[rd]==0 then pc=imm8 else pc+1; E NOP.
  - F HALT; D is reserved and behaves as NOP.
- Arithmetic is modulo 2^DATA_W. The carry/borrow bit is bit DATA_W of the extended result (borrow = rs1 < operand).
- FSM: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE -> FETCH when run=1 or step=1.
  - FETCH: imem_addr=pc.
  - DECODE: latch imem_data; read rs1/rs2/rd.
  - EXEC: compute result, flags, next pc.
  - WB: write rd, update pc, pulse retire. From WB go to HALT if op=F; else FETCH if run=1; else IDLE.
  - HALT is left only by reset.
- Latency is exactly 4 clk per instruction; the retire pulses are 4 cycles apart while run=1.
- step is ignored when not in IDLE. step and run together act as run.
- Writes to R0 are discarded and wb_en stays 0. A register written in WB is visible to the next instruction's DECODE (no hazard logic needed).
- Flags update only in WB of opcodes 0-A. Branches, NOP and HALT hold the flags.
- PC wraps: pc = 2^ADDR_W - 1 followed by a non-branch gives 0.
- Reset (any state, mid-instruction included): all registers 0, pc=0, flags 0, FSM=IDLE, every output 0, any partially executed instruction is discarded.

Test Plan:
- Reset low, ROM[0]=0x9105 (ADDI R1,R0,5), run=1 -> first retire 4 clk after IDLE exit; wb_addr=1, wb_data=0x0005, dbg_sel=1 gives 0x0005, flag_z=0, flag_c=0.
- R1=5, execute 0xA217 (SUBI R2,R1,7) -> wb_data=0xFFFE, flag_c=1, flag_z=0; then 0x1311 (SUB R3,R1,R1) -> 0x0000, flag_z=1, flag_c=0.
- 0x9003 (ADDI R0,R0,3) -> wb_en=0, dbg_sel=0 gives 0; retire still pulses.
- 0xC020 (BZ R0) -> pc=0x020. 0xC140 with R1=5 -> pc+1. 0xB123 -> pc=0x123. Non-branch at pc=0xFFF -> pc=0x000.
- run=0 with a step pulse -> exactly one retire, then IDLE with busy=0. A second step pulse during EXEC is ignored.
- 0xF000 -> halted=1 and busy=0, even with run=1 and step pulses. Then assert reset low in the DECODE of a later program -> pc=0, halted=0, all registers read 0 at once.

Source files
------------

// File: rtl/ula_multiciclo.sv
// Multi-cycle 16-instruction ALU core: FETCH/DECODE/EXEC/WB over a 16-entry register file,
// with flags, branches, HALT, run/step control and a combinational debug read port.
module ula_multiciclo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted,
    output logic              busy,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_SLT  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ANDI = 4'h6,
        OP_ORI  = 4'h7,
        OP_XORI = 4'h8,
        OP_ADDI = 4'h9,
        OP_SUBI = 4'hA,
        OP_JMP  = 4'hB,
        OP_BZ   = 4'hC,
        OP_RSVD = 4'hD,
        OP_NOP  = 4'hE,
        OP_HALT = 4'hF
    } op_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] regs [16];
    logic [15:0]       ir;
    logic [DATA_W-1:0] opa, opb, opd;

    logic [DATA_W-1:0] res_q;
    logic              carry_q;
    logic              zero_q;
    logic              wr_q;
    logic              upd_q;
    logic [ADDR_W-1:0] npc_q;

    op_t               op;
    logic [DATA_W-1:0] b_sel;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   dif;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_op;
    logic [ADDR_W-1:0] npc;
    logic [11:0]       imm8_ext;

    function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
        return (idx == 4'd0) ? '0 : regs[idx];
    endfunction

    assign op = op_t'(ir[15:12]);

    // Register-form ops (0-5) take rs2, immediate forms take zero-extended imm4.
    always_comb begin
        b_sel    = (ir[15:12] <= 4'h5) ? opb : {{(DATA_W-4){1'b0}}, ir[3:0]};
        sum      = {1'b0, opa} + {1'b0, b_sel};
        dif      = {1'b0, opa} - {1'b0, b_sel};
        imm8_ext = {4'h0, ir[7:0]};
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_op   = 1'b1;
        npc      = pc + ADDR_W'(1);
        unique case (op)
            OP_ADD, OP_ADDI: begin
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            OP_SUB, OP_SUBI: begin
                alu_res = dif[DATA_W-1:0];
                alu_c   = dif[DATA_W];
            end
            OP_SLT:          alu_res = (opa < b_sel) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            OP_AND, OP_ANDI: alu_res = opa & b_sel;
            OP_OR,  OP_ORI:  alu_res = opa | b_sel;
            OP_XOR, OP_XORI: alu_res = opa ^ b_sel;
            OP_JMP: begin
                alu_op = 1'b0;
                npc    = ir[ADDR_W-1:0];
            end
            OP_BZ: begin
                alu_op = 1'b0;
                if (opd == '0) npc = imm8_ext[ADDR_W-1:0];
            end
            default:         alu_op = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (run || step) state_nx = S_FETCH;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = S_EXEC;
            S_EXEC:   state_nx = S_WB;
            S_WB: begin
                if (op == OP_HALT) state_nx = S_HALT;
                else if (run)      state_nx = S_FETCH;
                else               state_nx = S_IDLE;
            end
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            opa     <= '0;
            opb     <= '0;
            opd     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            wr_q    <= 1'b0;
            upd_q   <= 1'b0;
            npc_q   <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_DECODE: begin
                    ir  <= imem_data;
                    opa <= rf_read(imem_data[7:4]);
                    opb <= rf_read(imem_data[3:0]);
                    opd <= rf_read(imem_data[11:8]);
                end
                S_EXEC: begin
                    res_q   <= alu_res;
                    carry_q <= alu_c;
                    zero_q  <= (alu_res == '0);
                    upd_q   <= alu_op;
                    wr_q    <= alu_op && (ir[11:8] != 4'd0);
                    npc_q   <= npc;
                end
                S_WB: begin
                    pc <= npc_q;
                    if (wr_q) regs[ir[11:8]] <= res_q;
                    if (upd_q) begin
                        flag_z <= zero_q;
                        flag_c <= carry_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign retire    = (state == S_WB);
    assign wb_en     = retire && wr_q;
    assign wb_addr   = retire ? ir[11:8] : 4'd0;
    assign wb_data   = retire ? res_q : '0;
    assign halted    = (state == S_HALT);
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign dbg_data  = rf_read(dbg_sel);

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: an instruction-level ISA model fills an expectation
// queue, and an independent monitor checks every retire against it.
module tb_ula_multiciclo;
    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_data = '0;
    logic [AW-1:0] pc;
    logic          retire, wb_en, flag_z, flag_c, halted, busy;
    logic [3:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic [3:0]    dbg_sel = '0;
    logic [DW-1:0] dbg_data;

    ula_multiciclo #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .retire(retire), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .busy(busy),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [4096];
    always @(posedge clk) imem_data <= rom[imem_addr];

    typedef struct {
        bit wen;
        int waddr;
        int wdata;
        int npc;
        bit z;
        bit c;
        bit halt;
    } exp_t;

    exp_t q[$];
    int   mregs[16];
    int   mpc;
    bit   mz, mc;
    int   vectors = 0;
    int   miscompares = 0;
    int   ncmp = 0;

    exp_t mon_cur;
    bit   mon_pend = 1'b0;
    int   mon_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 0;
        mpc = 0;
        mz  = 1'b0;
        mc  = 1'b0;
    endtask

    // Executes one instruction of the ISA with plain integer arithmetic.
    task automatic model_step(output exp_t e);
        int instr, op, rd, rs1, rs2, a, b, r;
        instr = int'(rom[mpc]);
        op  = (instr >> 12) & 15;
        rd  = (instr >> 8) & 15;
        rs1 = (instr >> 4) & 15;
        rs2 = instr & 15;
        e.wen = 1'b0; e.waddr = rd; e.wdata = 0; e.halt = 1'b0;
        e.npc = (mpc + 1) % 4096;
        a = mregs[rs1];
        b = (op <= 5) ? mregs[rs2] : rs2;
        r = 0;
        if (op <= 10) begin
            e.c = 1'b0;
            case (op)
                0, 9:  begin r = a + b; e.c = (r > 65535); r = r % 65536; end
                1, 10: begin e.c = (a < b); r = (a - b + 65536) % 65536; end
                2:     r = (a < b) ? 1 : 0;
                3, 6:  r = a & b;
                4, 7:  r = a | b;
                default: r = a ^ b;
            endcase
            e.z = (r == 0);
            e.wdata = r;
            e.wen = (rd != 0);
            if (rd != 0) mregs[rd] = r;
            mz = e.z;
            mc = e.c;
        end else begin
            e.z = mz;
            e.c = mc;
            if (op == 11) e.npc = instr & 12'hFFF;
            else if (op == 12 && mregs[rd] == 0) e.npc = instr & 8'hFF;
            else if (op == 15) e.halt = 1'b1;
        end
        mpc = e.npc;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_pend = 1'b0;
                mon_cnt  = 0;
            end else begin
                if (mon_pend) begin
                    if (!mon_cur.halt) check("pc_after", 32'(pc), mon_cur.npc);
                    check("flag_z", 32'(flag_z), 32'(mon_cur.z));
                    check("flag_c", 32'(flag_c), 32'(mon_cur.c));
                    check("halted", 32'(halted), 32'(mon_cur.halt));
                    mon_pend = 1'b0;
                end
                if (busy) mon_cnt++;
                else mon_cnt = 0;
                if (retire) begin
                    check("retire_latency", mon_cnt, 4);
                    mon_cnt = 0;
                    if (q.size() == 0) begin
                        ncmp++;
                        miscompares++;
                        $display("FAIL unexpected_retire: got retire at pc 0x%0h, expected none", pc);
                    end else begin
                        mon_cur = q.pop_front();
                        check("wb_en", 32'(wb_en), 32'(mon_cur.wen));
                        if (mon_cur.wen) begin
                            check("wb_addr", 32'(wb_addr), mon_cur.waddr);
                            check("wb_data", 32'(wb_data), mon_cur.wdata);
                        end
                        mon_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        q.delete();
        model_reset();
        #1;
        check("rst_pc", 32'(pc), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_retire", 32'(retire), 0);
        check("rst_wb_en", 32'(wb_en), 0);
        check("rst_wb_data", 32'(wb_data), 0);
        check("rst_flags", 32'({flag_z, flag_c}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_instrs(input int k, input bit keep_run);
        exp_t e;
        int seen, budget;
        for (int i = 0; i < k; i++) begin
            model_step(e);
            q.push_back(e);
            vectors++;
        end
        seen = 0;
        budget = 4 * k + 20;
        run = 1'b1;
        while (seen < k && budget > 0) begin
            @(negedge clk);
            if (retire) seen++;
            budget--;
        end
        if (!keep_run) run = 1'b0;
        check("run_retire_count", seen, k);
    endtask

    // Optional second pulse lands while the instruction is in EXEC.
    task automatic step_one(input bit double_pulse);
        exp_t e;
        int seen;
        model_step(e);
        q.push_back(e);
        vectors++;
        seen = 0;
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0; if (retire) seen++;
        @(negedge clk); if (retire) seen++;
        @(negedge clk); if (retire) seen++;
        if (double_pulse) step = 1'b1;
        @(negedge clk); step = 1'b0; if (retire) seen++;
        repeat (8) begin
            @(negedge clk);
            if (retire) seen++;
        end
        check("step_retires", seen, 1);
        check("step_idle_busy", 32'(busy), 0);
    endtask

    task automatic dbg_sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = i[3:0];
            #1;
            check(tag, 32'(dbg_data), mregs[i]);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] w;
        for (int i = 0; i < 4096; i++) rom[i] = 16'hE000;
        rom[0]      = 16'h9105;
        rom[1]      = 16'hA217;
        rom[2]      = 16'h1311;
        rom[3]      = 16'h9003;
        rom[4]      = 16'hC020;
        rom[12'h020] = 16'hC140;
        rom[12'h021] = 16'hB123;
        rom[12'h123] = 16'hBFFF;
        rom[12'hFFF] = 16'h9401;
        apply_reset();
        run_instrs(9, 1'b0);
        repeat (2) @(negedge clk);
        dbg_sweep("dbg_directed");
        step_one(1'b0);
        step_one(1'b1);
        dbg_sweep("dbg_after_step");

        for (int r = 0; r < 3; r++) begin
            apply_reset();
            for (int i = 0; i < 4096; i++) begin
                w = 16'($urandom_range(0, 65535));
                if (w[15:12] == 4'hF) w[15:12] = 4'hE;
                rom[i] = w;
            end
            run_instrs(120, 1'b0);
            repeat (2) @(negedge clk);
            step_one(1'b0);
            step_one(1'b1);
            run_instrs(30, 1'b0);
            repeat (3) @(negedge clk);
            dbg_sweep("dbg_random");
        end

        apply_reset();
        for (int i = 0; i < 4096; i++) rom[i] = 16'hE000;
        rom[0] = 16'h9107;
        rom[1] = 16'hF000;
        rom[2] = 16'h9201;
        run_instrs(2, 1'b1);
        repeat (6) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
        check("halt_stays", 32'(halted), 1);
        check("halt_not_busy", 32'(busy), 0);
        run = 1'b0;
        dbg_sweep("dbg_halt");
        check("queue_drained", q.size(), 0);

        apply_reset();
        rom[0] = 16'h9105;
        rom[1] = 16'h9203;
        rom[2] = 16'h0312;
        run_instrs(2, 1'b0);
        repeat (2) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        check("pc_before_reset", 32'(pc), mpc);
        @(negedge clk);
        reset = 1'b0;
        run = 1'b0;
        model_reset();
        #1;
        check("mid_rst_pc", 32'(pc), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_halted", 32'(halted), 0);
        check("mid_rst_retire", 32'(retire), 0);
        dbg_sweep("dbg_mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
